// File: rtl/ogege_bus_pkg.sv
// Shared bus definitions for the CPU bus responders: FSM state encoding,
// region constants and bus widths.
package ogege_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    // Upper half of the 32-bit address that selects the BRAM region.
    localparam logic [15:0] BRAM_PERIPH_BASE_HIGH_PART = 16'h0000;

    // High byte of the low 16 address bits that marks the I/O window.
    localparam logic [7:0]  IO_WIN_HI = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RDATA,
        DONE
    } bram_state_t;

endpackage

// File: rtl/bram_sp8.sv
// Single-port synchronous byte RAM with a registered read port.
// Read-first: on a write cycle dout returns the old contents.
// Contents are not reset.
module bram_sp8 #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);

    logic [7:0] mem [2**ADDR_W];

    // Byte write and registered read on the same address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/bram_periph.sv
// BRAM bus responder: turns a level strobe from the CPU bus into a single
// byte read or write of the on-chip RAM, with a ready handshake that is held
// until the strobe drops. Accesses to the I/O window are ignored.
//
// Optional feature macro: BRAM_PERIPH_WPROT_EN
//   Adds parameter WPROT_TOP and output o_wprot_err. Writes to addresses at or
//   below WPROT_TOP are dropped, the handshake still completes, and
//   o_wprot_err becomes set until reset.
//
// state  | meaning
// IDLE   | waiting for a strobe rising edge in the region
// WAIT   | inserting WAIT_STATES idle cycles
// ACCESS | latched address on the RAM, write happens here
// RDATA  | RAM output valid, capture read data, raise ready
// DONE   | hold ready until the strobe drops
module bram_periph
    import ogege_bus_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_STATES = 0,
`ifdef BRAM_PERIPH_WPROT_EN
    parameter logic [15:0] WPROT_TOP   = 16'h00FF,
`endif
    parameter logic [7:0]  IO_HI       = IO_WIN_HI
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              o_data_ready,
`ifdef BRAM_PERIPH_WPROT_EN
    output logic              o_wprot_err,
`endif
    output logic              o_busy
);

    // The counter is loaded with WAIT_STATES-1 so WAIT lasts exactly
    // WAIT_STATES cycles before ACCESS.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bram_state_t       state_q, state_d;
    logic              stb_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              wprot_q, wprot_d;

    logic              start;
    logic              prot_hit;
    logic              ram_we;
    logic [7:0]        ram_dout;

    assign start = i_stb & ~stb_q & i_cs
                 & (i_addr[ADDR_W-1 -: 8] != IO_HI)
                 & (state_q == IDLE);

`ifdef BRAM_PERIPH_WPROT_EN
    assign prot_hit    = (addr_q <= ADDR_W'(WPROT_TOP));
    assign o_wprot_err = wprot_q;
`else
    assign prot_hit    = 1'b0;
`endif

    assign ram_we = (state_q == ACCESS) & we_q & ~prot_hit;

    bram_sp8 #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk (i_clk),
        .we  (ram_we),
        .addr(addr_q),
        .din (wdata_q),
        .dout(ram_dout)
    );

    // State and datapath registers; strobe delayed for rising-edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            cnt_q   <= 4'd0;
            rdata_q <= 8'h00;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            wprot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= i_stb;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            wprot_q <= wprot_d;
        end
    end

    // Next-state and next-output logic for the access sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        wprot_d = wprot_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = i_addr;
                    we_d    = i_we;
                    wdata_d = i_data;
                    busy_d  = 1'b1;
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            ACCESS: begin
                state_d = RDATA;
            end
            RDATA: begin
                if (!we_q) begin
                    rdata_d = ram_dout;
                end
                if (we_q && prot_hit) begin
                    wprot_d = 1'b1;
                end
                rdy_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!i_stb) begin
                    rdy_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_data       = rdata_q;
    assign o_data_ready = rdy_q;
    assign o_busy       = busy_q;

endmodule
